// File: rtl/adbg_wb_pkg.sv
// Shared definitions for the WB debug serial DR protocol: opcodes, frame layout,
// initiator state encoding and opcode-derived helpers.
package adbg_wb_pkg;

    localparam int FRAME_LEN = 53;
    localparam int CNT_LSB   = 0;
    localparam int ADR_LSB   = 16;
    localparam int OP_LSB    = 48;
    localparam int SEL_BIT   = 52;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_BWRITE8  = 4'h1;
    localparam logic [3:0] OP_BWRITE16 = 4'h2;
    localparam logic [3:0] OP_BWRITE32 = 4'h3;
    localparam logic [3:0] OP_BWRITE64 = 4'h4;
    localparam logic [3:0] OP_BREAD8   = 4'h5;
    localparam logic [3:0] OP_BREAD16  = 4'h6;
    localparam logic [3:0] OP_BREAD32  = 4'h7;
    localparam logic [3:0] OP_BREAD64  = 4'h8;
    localparam logic [3:0] OP_IREG_WR  = 4'h9;
    localparam logic [3:0] OP_IREG_SEL = 4'hD;

    typedef enum logic [3:0] {
        S_IDLE, S_ERR, S_HDR, S_WDATA, S_WCRC, S_WSTAT,
        S_RSTART, S_RDATA, S_RCRC, S_DONE
    } state_t;

    function automatic logic is_write(input logic [3:0] op);
        return op inside {OP_BWRITE8, OP_BWRITE16, OP_BWRITE32, OP_BWRITE64};
    endfunction

    function automatic logic is_read(input logic [3:0] op);
        return op inside {OP_BREAD8, OP_BREAD16, OP_BREAD32, OP_BREAD64};
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {OP_NOP, OP_IREG_WR, OP_IREG_SEL} || is_write(op) || is_read(op);
    endfunction

    // Index of the last bit of a payload word (word width - 1).
    function automatic logic [5:0] word_last_bit(input logic [3:0] op);
        case (op)
            OP_BWRITE8,  OP_BREAD8:  return 6'd7;
            OP_BWRITE16, OP_BREAD16: return 6'd15;
            OP_BWRITE32, OP_BREAD32: return 6'd31;
            default:                 return 6'd63;
        endcase
    endfunction

    function automatic logic [FRAME_LEN-1:0] make_frame(input logic [3:0] op,
                                                        input logic [31:0] adr,
                                                        input logic [15:0] cnt);
        logic [FRAME_LEN-1:0] f;
        f                = '0;
        f[CNT_LSB +: 16] = cnt;
        f[ADR_LSB +: 32] = adr;
        f[OP_LSB +: 4]   = op;
        f[SEL_BIT]       = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/adbg_wb_cmd_tx_if.sv
// Command, payload and DR-serial signals of the WB debug command initiator.
interface adbg_wb_cmd_tx_if #(parameter int ADR_W = 32);
    import adbg_wb_pkg::*;

    // cmd and wr channels: a transfer happens on a clock edge where valid and ready
    // are both high; valid may not depend on ready, ready may depend on valid.
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [3:0]       cmd_op_i;
    logic [ADR_W-1:0] cmd_adr_i;
    logic [15:0]      cmd_cnt_i;
    logic [63:0]      wr_data_i;
    logic             wr_valid_i;
    logic             wr_ready_o;
    logic [63:0]      rd_data_o;
    logic             rd_valid_o;
    logic             tdi_o;
    logic             shift_o;
    logic             tdo_i;
    logic             done_o;
    logic             status_o;
    logic             err_o;
    state_t           dbg_state;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_cnt_i, wr_data_i, wr_valid_i, tdo_i,
        output cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, tdi_o, shift_o,
               done_o, status_o, err_o, dbg_state
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_cnt_i, wr_data_i, wr_valid_i, tdo_i,
        input  cmd_ready_o, wr_ready_o, rd_data_o, rd_valid_o, tdi_o, shift_o,
               done_o, status_o, err_o, dbg_state
    );

endinterface

// File: rtl/adbg_crc32_serial.sv
// Bit-serial reflected CRC-32 (poly 0xEDB88320, init all ones, no final inversion).
module adbg_crc32_serial (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        din_i,
    output logic [31:0] crc_o
);
    localparam logic [31:0] POLY = 32'hEDB88320;

    logic [31:0] r_crc;
    logic        w_fb;

    assign w_fb  = r_crc[0] ^ din_i;
    assign crc_o = r_crc;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (en_i) begin
            r_crc <= (r_crc >> 1) ^ (w_fb ? POLY : 32'h0);
        end
    end

endmodule

// File: rtl/adbg_wb_cmd_tx.sv
// Host-side initiator: shifts the 53-bit command frame out on TDI, then streams
// write payload + CRC or collects read payload and checks its CRC.
module adbg_wb_cmd_tx
    import adbg_wb_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             tck_i,
    input  logic             rst_i,
    adbg_wb_cmd_tx_if.slave  bus
);
    state_t      r_state, w_next;
    logic [3:0]  r_op;
    logic [5:0]  r_bit;
    logic [15:0] r_wcnt;
    logic [10:0] r_tmo;
    logic [63:0] r_sr;
    logic [63:0] r_rd;
    logic        r_rd_valid;
    logic        r_status;

    logic        w_ready, w_accept, w_word_end;
    logic        w_shift, w_tdi, w_wr_ready, w_crc_en, w_crc_din;
    logic [31:0] w_crc;

    assign w_ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept   = bus.cmd_valid_i && w_ready;
    assign w_word_end = (r_bit == word_last_bit(r_op));

    adbg_crc32_serial u_crc (
        .clk_i (tck_i),
        .rst_i (rst_i),
        .clr_i (w_accept),
        .en_i  (w_crc_en),
        .din_i (w_crc_din),
        .crc_o (w_crc)
    );

    always_comb begin
        w_next     = r_state;
        w_shift    = 1'b0;
        w_tdi      = 1'b0;
        w_wr_ready = 1'b0;
        w_crc_en   = 1'b0;
        w_crc_din  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next = S_IDLE;
                if (w_accept) begin
                    if (!is_legal(bus.cmd_op_i) ||
                        ((is_write(bus.cmd_op_i) || is_read(bus.cmd_op_i)) && bus.cmd_cnt_i == 16'd0))
                        w_next = S_ERR;
                    else
                        w_next = S_HDR;
                end
            end
            S_ERR: w_next = S_IDLE;
            S_HDR: begin
                w_shift = 1'b1;
                w_tdi   = r_sr[0];
                if (r_bit == 6'(FRAME_LEN - 1))
                    w_next = is_write(r_op) ? S_WDATA : (is_read(r_op) ? S_RSTART : S_DONE);
            end
            S_WDATA: begin
                // A new word starts only when one is offered; otherwise the DR stalls.
                if (r_bit != 6'd0 || bus.wr_valid_i) begin
                    w_shift    = 1'b1;
                    w_tdi      = (r_bit == 6'd0) ? bus.wr_data_i[0] : r_sr[0];
                    w_wr_ready = (r_bit == 6'd0);
                    w_crc_en   = 1'b1;
                    w_crc_din  = w_tdi;
                    if (w_word_end && r_wcnt == 16'd1) w_next = S_WCRC;
                end
            end
            S_WCRC: begin
                w_shift = 1'b1;
                w_tdi   = w_crc[r_bit[4:0]];
                if (r_bit == 6'd31) w_next = S_WSTAT;
            end
            S_WSTAT: begin
                w_shift = 1'b1;
                w_next  = S_DONE;
            end
            S_RSTART: begin
                w_shift = 1'b1;
                if (bus.tdo_i) w_next = S_RDATA;
                else if (r_tmo == 11'(TIMEOUT - 1)) w_next = S_ERR;
            end
            S_RDATA: begin
                w_shift   = 1'b1;
                w_crc_en  = 1'b1;
                w_crc_din = bus.tdo_i;
                if (w_word_end && r_wcnt == 16'd1) w_next = S_RCRC;
            end
            S_RCRC: begin
                w_shift = 1'b1;
                if (r_bit == 6'd31) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_op       <= 4'h0;
            r_bit      <= 6'd0;
            r_wcnt     <= 16'd0;
            r_tmo      <= 11'd0;
            r_sr       <= 64'd0;
            r_rd       <= 64'd0;
            r_rd_valid <= 1'b0;
            r_status   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op   <= bus.cmd_op_i;
                        r_sr   <= 64'(make_frame(bus.cmd_op_i, bus.cmd_adr_i[ADR_W-1:0], bus.cmd_cnt_i));
                        r_wcnt <= bus.cmd_cnt_i;
                        r_bit  <= 6'd0;
                    end
                end
                S_HDR: begin
                    r_sr  <= r_sr >> 1;
                    r_bit <= (r_bit == 6'(FRAME_LEN - 1)) ? 6'd0 : r_bit + 6'd1;
                    r_tmo <= 11'd0;
                end
                S_WDATA: begin
                    if (w_shift) begin
                        r_sr <= (r_bit == 6'd0) ? (bus.wr_data_i >> 1) : (r_sr >> 1);
                        if (w_word_end) begin
                            r_bit  <= 6'd0;
                            r_wcnt <= r_wcnt - 16'd1;
                        end else begin
                            r_bit <= r_bit + 6'd1;
                        end
                    end
                end
                S_WCRC:  r_bit <= (r_bit == 6'd31) ? 6'd0 : r_bit + 6'd1;
                S_WSTAT: r_status <= bus.tdo_i;
                S_RSTART: begin
                    r_tmo <= r_tmo + 11'd1;
                    if (w_next == S_ERR) r_status <= 1'b0;
                end
                S_RDATA: begin
                    r_rd <= (r_bit == 6'd0) ? {63'd0, bus.tdo_i} : (r_rd | (64'(bus.tdo_i) << r_bit));
                    if (w_word_end) begin
                        r_rd_valid <= 1'b1;
                        r_bit      <= 6'd0;
                        r_wcnt     <= r_wcnt - 16'd1;
                    end else begin
                        r_bit <= r_bit + 6'd1;
                    end
                end
                S_RCRC: begin
                    // Received CRC enters at the top and walks down; bit 31 arrives last.
                    r_sr  <= {bus.tdo_i, r_sr[63:1]};
                    r_bit <= (r_bit == 6'd31) ? 6'd0 : r_bit + 6'd1;
                    if (r_bit == 6'd31) r_status <= ({bus.tdo_i, r_sr[63:33]} == w_crc);
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready_o = w_ready;
    assign bus.wr_ready_o  = w_wr_ready;
    assign bus.rd_data_o   = r_rd;
    assign bus.rd_valid_o  = r_rd_valid;
    assign bus.tdi_o       = w_tdi;
    assign bus.shift_o     = w_shift;
    assign bus.done_o      = (r_state == S_DONE);
    assign bus.err_o       = (r_state == S_ERR);
    assign bus.status_o    = r_status;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_adbg_wb_cmd_tx.sv
// Directed bench for adbg_wb_cmd_tx: header framing, write/read bursts, CRC,
// stall, timeout, error and reset cases.
module tb_adbg_wb_cmd_tx;
    import adbg_wb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adbg_wb_cmd_tx_if #(.ADR_W(32)) u_if ();

    adbg_wb_cmd_tx #(.ADR_W(32), .TIMEOUT(1024)) dut (
        .tck_i (clk),
        .rst_i (rst),
        .bus   (u_if)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc;
    int n_shift, n_wrrdy, n_rdv, n_done, n_err;
    logic [0:0]  mon_bits[$];
    logic [0:0]  exp_q[$];
    logic [63:0] rd_q[$];
    logic [63:0] exp_rd[$];

    always @(negedge clk) begin
        if (u_if.shift_o === 1'b1) begin
            mon_bits.push_back(u_if.tdi_o);
            n_shift++;
        end
        if (u_if.wr_ready_o === 1'b1) n_wrrdy++;
        if (u_if.rd_valid_o === 1'b1) begin
            rd_q.push_back(u_if.rd_data_o);
            n_rdv++;
        end
        if (u_if.done_o === 1'b1) n_done++;
        if (u_if.err_o === 1'b1) n_err++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return (c >> 1) ^ ((c[0] ^ b) ? 32'hEDB88320 : 32'h0);
    endfunction

    task automatic clr_mon();
        mon_bits.delete(); exp_q.delete(); rd_q.delete(); exp_rd.delete();
        n_shift = 0; n_wrrdy = 0; n_rdv = 0; n_done = 0; n_err = 0;
    endtask

    task automatic push_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    // Frame on the wire: cnt[0] first ... cnt[15], adr[0..31], op[0..3], select bit 0.
    task automatic push_frame(input logic [3:0] op, input logic [31:0] adr, input logic [15:0] cnt);
        push_bits({48'd0, cnt}, 16);
        push_bits({32'd0, adr}, 32);
        push_bits({60'd0, op}, 4);
        push_bits(64'd0, 1);
    endtask

    task automatic chk_stream(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= mon_bits.size() || mon_bits[i] !== exp_q[i]) bad++;
        chk({tag, "_len"}, 64'(mon_bits.size()), 64'(exp_q.size()));
        chk({tag, "_bits_wrong"}, 64'(bad), 64'd0);
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [31:0] adr, input logic [15:0] cnt);
        @(posedge clk); #1;
        u_if.cmd_op_i = op; u_if.cmd_adr_i = adr; u_if.cmd_cnt_i = cnt;
        u_if.cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        u_if.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        cyc = 0;
        while (u_if.done_o !== 1'b1 && cyc < bound) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic end_txn(input string tag, input int exp_cyc);
        chk({tag, "_done"}, 64'(u_if.done_o), 64'd1);
        chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        @(posedge clk); #1;
        chk({tag, "_ready"}, 64'(u_if.cmd_ready_o), 64'd1);
        chk({tag, "_ndone"}, 64'(n_done), 64'd1);
    endtask

    task automatic wait_wr_ready();
        int g;
        g = 0;
        @(negedge clk);
        while (u_if.wr_ready_o !== 1'b1 && g < 300) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic run_write(input int stall, input logic tdo_val, input string tag);
        logic [31:0] w[2];
        logic [31:0] c;
        w[0] = 32'hDEADBEEF; w[1] = 32'h12345678;
        clr_mon();
        push_frame(OP_BWRITE32, 32'h1000_0000, 16'd2);
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++)
            for (int b = 0; b < 32; b++) begin
                exp_q.push_back(w[k][b]);
                c = crc_bit(c, w[k][b]);
            end
        push_bits({32'd0, c}, 32);
        push_bits(64'd0, 1);
        u_if.tdo_i = tdo_val; u_if.wr_data_i = {32'd0, w[0]}; u_if.wr_valid_i = 1'b1;
        send_cmd(OP_BWRITE32, 32'h1000_0000, 16'd2);
        fork
            begin
                wait_wr_ready();
                @(posedge clk); #1;
                u_if.wr_data_i = {32'hFFFF_FFFF, w[1]};
                if (stall > 0) begin
                    u_if.wr_valid_i = 1'b0;
                    repeat (31 + stall) @(posedge clk);
                    #1 u_if.wr_valid_i = 1'b1;
                end
                wait_wr_ready();
                @(posedge clk); #1;
                u_if.wr_valid_i = 1'b0;
            end
            wait_done(400);
        join
        end_txn(tag, 150 + stall);
        chk_stream(tag);
        chk({tag, "_shifts"}, 64'(n_shift), 64'd150);
        chk({tag, "_wr_ready_pulses"}, 64'(n_wrrdy), 64'd2);
        chk({tag, "_status"}, 64'(u_if.status_o), 64'(tdo_val));
    endtask

    task automatic run_read(input logic flip, input string tag);
        logic [15:0] w[3];
        logic [31:0] c, rx;
        w[0] = 16'hA5A5; w[1] = 16'h0001; w[2] = 16'hFFFF;
        clr_mon();
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            exp_rd.push_back({48'd0, w[k]});
            for (int b = 0; b < 16; b++) c = crc_bit(c, w[k][b]);
        end
        rx = flip ? (c ^ 32'h0000_0100) : c;
        u_if.tdo_i = 1'b0;
        send_cmd(OP_BREAD16, 32'h2000_0040, 16'd3);
        repeat (53 + 10) @(posedge clk);
        #1 u_if.tdo_i = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < 16; b++) begin
                u_if.tdo_i = w[k][b];
                @(posedge clk); #1;
            end
        for (int b = 0; b < 32; b++) begin
            u_if.tdo_i = rx[b];
            @(posedge clk); #1;
        end
        u_if.tdo_i = 1'b0;
        wait_done(4);
        end_txn(tag, 0);
        chk({tag, "_rd_pulses"}, 64'(n_rdv), 64'd3);
        for (int k = 0; k < 3; k++)
            chk({tag, "_word"}, (k < rd_q.size()) ? rd_q[k] : 64'hx, exp_rd[k]);
        chk({tag, "_status"}, 64'(u_if.status_o), 64'(!flip));
    endtask

    task automatic run_illegal(input logic [3:0] op, input logic [15:0] cnt, input string tag);
        clr_mon();
        send_cmd(op, 32'h0000_0010, cnt);
        chk({tag, "_err"}, 64'(u_if.err_o), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_err_clear"}, 64'(u_if.err_o), 64'd0);
        chk({tag, "_ready"}, 64'(u_if.cmd_ready_o), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_shifts"}, 64'(n_shift), 64'd0);
        chk({tag, "_nerr"}, 64'(n_err), 64'd1);
        chk({tag, "_ndone"}, 64'(n_done), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        u_if.cmd_valid_i = 1'b0; u_if.cmd_op_i = 4'h0; u_if.cmd_adr_i = 32'h0;
        u_if.cmd_cnt_i = 16'h0; u_if.wr_data_i = 64'h0; u_if.wr_valid_i = 1'b0;
        u_if.tdo_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(u_if.cmd_ready_o), 64'd1);
        chk("rst_shift", 64'(u_if.shift_o), 64'd0);
        chk("rst_tdi", 64'(u_if.tdi_o), 64'd0);
        chk("rst_done", 64'(u_if.done_o), 64'd0);
        chk("rst_err", 64'(u_if.err_o), 64'd0);
        chk("rst_status", 64'(u_if.status_o), 64'd0);
        chk("rst_rd_valid", 64'(u_if.rd_valid_o), 64'd0);
        chk("rst_rd_data", u_if.rd_data_o, 64'd0);
        rst = 1'b0;

        clr_mon();
        push_frame(OP_NOP, 32'h0, 16'h0);
        send_cmd(OP_NOP, 32'h0, 16'h0);
        wait_done(100);
        end_txn("nop", 53);
        chk_stream("nop");
        chk("nop_status", 64'(u_if.status_o), 64'd0);

        clr_mon();
        push_frame(OP_IREG_SEL, 32'h8000_0001, 16'h0003);
        send_cmd(OP_IREG_SEL, 32'h8000_0001, 16'h0003);
        wait_done(100);
        end_txn("ireg_sel", 53);
        chk_stream("ireg_sel");

        run_write(5, 1'b0, "wr_stall");
        run_write(0, 1'b1, "wr_nostall");
        run_read(1'b1, "rd_badcrc");
        run_read(1'b0, "rd_good");

        clr_mon();
        u_if.tdo_i = 1'b0;
        send_cmd(OP_BREAD8, 32'h3000_0000, 16'd1);
        repeat (53 + 1023) @(posedge clk);
        #1;
        chk("tmo_still_waiting", 64'(u_if.shift_o), 64'd1);
        chk("tmo_no_err_early", 64'(u_if.err_o), 64'd0);
        @(posedge clk); #1;
        chk("tmo_err", 64'(u_if.err_o), 64'd1);
        chk("tmo_status", 64'(u_if.status_o), 64'd0);
        @(posedge clk); #1;
        chk("tmo_ready", 64'(u_if.cmd_ready_o), 64'd1);
        chk("tmo_rd_pulses", 64'(n_rdv), 64'd0);
        chk("tmo_ndone", 64'(n_done), 64'd0);

        run_illegal(4'hB, 16'd1, "op_0xB");
        run_illegal(OP_BWRITE8, 16'd0, "bwrite8_cnt0");
        run_read(1'b0, "rd_again");

        clr_mon();
        u_if.wr_data_i = 64'h0000_0000_CAFE_F00D; u_if.wr_valid_i = 1'b1;
        send_cmd(OP_BWRITE32, 32'h1000_0000, 16'd2);
        repeat (60) @(posedge clk);
        #1;
        chk("mid_wdata_shift", 64'(u_if.shift_o), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_cmd_ready", 64'(u_if.cmd_ready_o), 64'd1);
        chk("arst_shift", 64'(u_if.shift_o), 64'd0);
        chk("arst_tdi", 64'(u_if.tdi_o), 64'd0);
        chk("arst_wr_ready", 64'(u_if.wr_ready_o), 64'd0);
        chk("arst_done", 64'(u_if.done_o), 64'd0);
        chk("arst_err", 64'(u_if.err_o), 64'd0);
        chk("arst_status", 64'(u_if.status_o), 64'd0);
        chk("arst_rd_data", u_if.rd_data_o, 64'd0);
        rst = 1'b0;
        u_if.wr_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_done", 64'(n_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
